// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with zeroed bubbles and synchronous flush.
// Define PIPE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int OP_W   = 4,
  parameter int DATA_W = 8,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_value,
  input  logic [DATA_W-1:0] in_label,
  input  logic [DATA_W-1:0] in_regA,
  input  logic [DATA_W-1:0] in_regB,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_opcode,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] out_label,
  output logic [DATA_W-1:0] out_regA,
  output logic [DATA_W-1:0] out_regB,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int PW = OP_W + 4*DATA_W + FLAG_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
`ifdef PIPE_SKID_EN
  localparam logic [1:0] TWO   = 2'd2;
`endif

  logic [1:0]    state;
  logic [1:0]    stateN;
  logic [PW-1:0] mainQ;
  logic [PW-1:0] mainN;
  logic [PW-1:0] inPay;
  logic          inXfer;
  logic          outXfer;

  assign inPay = {in_opcode, in_value, in_label,
                  in_regA, in_regB, in_flags};

  // Main entry is zeroed whenever it empties, so bubbles read as zero.
  assign {out_opcode, out_value, out_label,
          out_regA, out_regB, out_flags} = mainQ;

  assign out_valid = (state != EMPTY);
  assign outXfer   = out_valid && out_ready;
  assign inXfer    = in_valid && in_ready && !flush;

`ifdef PIPE_SKID_EN
  logic [PW-1:0] skidQ;
  logic [PW-1:0] skidN;
  logic          inReadyQ;

  assign in_ready = inReadyQ;
`else
  assign in_ready = out_ready || !out_valid;
`endif

  always_comb begin
    stateN = state;
    mainN  = mainQ;
`ifdef PIPE_SKID_EN
    skidN  = skidQ;
`endif
    if (flush) begin
      stateN = EMPTY;
      mainN  = '0;
`ifdef PIPE_SKID_EN
      skidN  = '0;
`endif
    end else begin
      unique case (state)
        EMPTY: begin
          if (inXfer) begin
            stateN = ONE;
            mainN  = inPay;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainN = inPay;
          end else if (outXfer) begin
            stateN = EMPTY;
            mainN  = '0;
`ifdef PIPE_SKID_EN
          end else if (inXfer) begin
            stateN = TWO;
            skidN  = inPay;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (outXfer) begin
            stateN = ONE;
            mainN  = skidQ;
            skidN  = '0;
          end
        end
`endif
        default: begin
          stateN = EMPTY;
          mainN  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      mainQ <= '0;
    end else begin
      state <= stateN;
      mainQ <= mainN;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidQ    <= '0;
      inReadyQ <= 1'b1;
    end else begin
      skidQ    <= skidN;
      inReadyQ <= (stateN != TWO);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus reset,
// backpressure, flush and async-reset sequences.
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_value;
  logic [7:0] in_label;
  logic [7:0] in_regA;
  logic [7:0] in_regB;
  logic [4:0] in_flags;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_opcode;
  logic [7:0] out_value;
  logic [7:0] out_label;
  logic [7:0] out_regA;
  logic [7:0] out_regB;
  logic [4:0] out_flags;

  int nVec  = 0;
  int nFail = 0;

  pipe_stage_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_value   (in_value),
    .in_label   (in_label),
    .in_regA    (in_regA),
    .in_regB    (in_regB),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_value  (out_value),
    .out_label  (out_label),
    .out_regA   (out_regA),
    .out_regB   (out_regB),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       inValid;
    logic [3:0] op;
    logic [7:0] val;
    logic       outReady;
    logic       fl;
    logic       chkRdy;
    logic       expRdy;
    logic       expValid;
    logic [3:0] expOp;
    logic [7:0] expVal;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Side fields are derived from value/opcode so they get checked too.
  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [7:0] val);
    in_valid  = v;
    in_opcode = op;
    in_value  = val;
    in_label  = val ^ 8'h5A;
    in_regA   = ~val;
    in_regB   = {val[3:0], val[7:4]};
    in_flags  = {1'b1, op};
  endtask

  task automatic checkOut(input string name, input logic ev,
                          input logic [3:0] eop, input logic [7:0] eval);
    logic [7:0] lab;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [4:0] fl;
    lab = ev ? (eval ^ 8'h5A) : 8'h00;
    ra  = ev ? ~eval : 8'h00;
    rb  = ev ? {eval[3:0], eval[7:4]} : 8'h00;
    fl  = ev ? {1'b1, eop} : 5'h00;
    check({name, ".valid"}, int'(out_valid), int'(ev));
    check({name, ".opcode"}, int'(out_opcode), int'(ev ? eop : 4'h0));
    check({name, ".value"}, int'(out_value), int'(ev ? eval : 8'h00));
    check({name, ".label"}, int'(out_label), int'(lab));
    check({name, ".regA"}, int'(out_regA), int'(ra));
    check({name, ".regB"}, int'(out_regB), int'(rb));
    check({name, ".flags"}, int'(out_flags), int'(fl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 4'(i + 1), 8'h10 + 8'(i), 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b1, 4'(i + 1), 8'h10 + 8'(i)};
    end
    vecs[8]  = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b0,
                 1'b1, 1'b1, 1'b0, 4'h0, 8'h00};
    vecs[9]  = '{1'b1, 4'h9, 8'h99, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 4'h9, 8'h99};
    vecs[10] = '{1'b1, 4'h7, 8'h77, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[11] = '{1'b0, 4'h0, 8'h00, 1'b1, 1'b0,
                 1'b1, 1'b1, 1'b0, 4'h0, 8'h00};

    // Reset with a valid payload presented
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'hA, 8'hA5);
    tick();
    tick();
    checkOut("rst", 1'b0, 4'h0, 8'h00);
    check("rst.in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    tick();
    checkOut("rst.first", 1'b1, 4'hA, 8'hA5);
    drive(1'b0, 4'h0, 8'h00);
    tick();
    checkOut("rst.drain", 1'b0, 4'h0, 8'h00);

    // Table: streaming, then flush of a held entry
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].inValid, vecs[i].op, vecs[i].val);
      out_ready = vecs[i].outReady;
      flush     = vecs[i].fl;
      #2;
      if (vecs[i].chkRdy)
        check($sformatf("v%0d.in_ready", i), int'(in_ready),
              int'(vecs[i].expRdy));
      tick();
      checkOut($sformatf("v%0d", i), vecs[i].expValid,
               vecs[i].expOp, vecs[i].expVal);
    end
    flush = 1'b0;

`ifdef PIPE_SKID_EN
    // Backpressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 8'h33);
    tick();
    checkOut("bp.a", 1'b1, 4'h3, 8'h33);
    check("bp.a.in_ready", int'(in_ready), 1);
    drive(1'b1, 4'h4, 8'h44);
    tick();
    checkOut("bp.b", 1'b1, 4'h3, 8'h33);
    check("bp.b.in_ready", int'(in_ready), 0);
    drive(1'b1, 4'hE, 8'hEE);
    tick();
    checkOut("bp.hold", 1'b1, 4'h3, 8'h33);
    check("bp.hold.in_ready", int'(in_ready), 0);
    drive(1'b0, 4'h0, 8'h00);
    out_ready = 1'b1;
    tick();
    checkOut("bp.out4", 1'b1, 4'h4, 8'h44);
    check("bp.out4.in_ready", int'(in_ready), 1);
    tick();
    checkOut("bp.empty", 1'b0, 4'h0, 8'h00);

    // Flush from TWO with a payload presented
    out_ready = 1'b0;
    drive(1'b1, 4'h5, 8'h55);
    tick();
    drive(1'b1, 4'h6, 8'h66);
    tick();
    check("fl.full.in_ready", int'(in_ready), 0);
    drive(1'b1, 4'h7, 8'h77);
    flush = 1'b1;
    tick();
    checkOut("fl.two", 1'b0, 4'h0, 8'h00);
    check("fl.two.in_ready", int'(in_ready), 1);
    flush = 1'b0;
    drive(1'b0, 4'h0, 8'h00);
    out_ready = 1'b1;
    tick();
    checkOut("fl.after", 1'b0, 4'h0, 8'h00);
`else
    // Combinational in_ready follows out_ready when full
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 8'h33);
    tick();
    checkOut("nr.full", 1'b1, 4'h3, 8'h33);
    check("nr.in_ready0", int'(in_ready), 0);
    drive(1'b1, 4'hE, 8'hEE);
    tick();
    checkOut("nr.hold", 1'b1, 4'h3, 8'h33);
    out_ready = 1'b1;
    #1;
    check("nr.in_ready1", int'(in_ready), 1);
    drive(1'b0, 4'h0, 8'h00);
    tick();
    checkOut("nr.empty", 1'b0, 4'h0, 8'h00);
`endif

    // Asynchronous reset between edges
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 8'hFF);
    tick();
    checkOut("ar.pre", 1'b1, 4'h1, 8'hFF);
    drive(1'b0, 4'h0, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    checkOut("ar.now", 1'b0, 4'h0, 8'h00);
    check("ar.in_ready", int'(in_ready), 1);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'h2, 8'h22);
    tick();
    checkOut("ar.resume", 1'b1, 4'h2, 8'h22);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter OP_W, default 4, opcode width.
REQ-002 Parameter DATA_W, default 8, width of value, label value, regA, regB.
REQ-003 Parameter FLAG_W, default 5, flag vector width; bits: [0] label, [1] writeMem, [2] readMem, [3] immediate, [4] sign.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 flush  input  1  synchronous invalidate of all held entries.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage accepts payload this cycle.
REQ-009 in_opcode, in_value, in_label, in_regA, in_regB  input  OP_W / DATA_W each  upstream payload fields.
REQ-010 in_flags  input  FLAG_W  upstream flag vector.
REQ-011 out_valid  output  1  downstream payload valid.
REQ-012 out_ready  input  1  downstream accepts payload.
REQ-013 out_opcode, out_value, out_label, out_regA, out_regB, out_flags  output  widths as inputs  downstream payload.

Function
REQ-014 Input transfer SHALL occur on a rising edge with in_valid && in_ready && !flush.
REQ-015 Output transfer SHALL occur on a rising edge with out_valid && out_ready.
REQ-016 Payload SHALL pass unmodified, in order, with no loss or duplication; minimum latency one cycle (accepted at edge N, out_valid at edge N+1).
REQ-017 Stage SHALL hold a main entry driving outputs; payload and out_valid SHALL be stable while out_valid && !out_ready.
REQ-018 When out_valid is 0, all payload outputs SHALL read zero (bubble = opcode 0, all flags 0).
REQ-019 Occupancy states: EMPTY, ONE (main only), TWO (main + skid, PIPE_SKID_EN only).
REQ-020 EMPTY: input transfer -> ONE.
REQ-021 ONE: input and output transfer in same cycle -> ONE with new payload; output only -> EMPTY; input only -> TWO (new payload into skid).
REQ-022 TWO: in_ready SHALL be 0; output transfer -> ONE, skid payload moves to main the same edge.
REQ-023 flush SHALL, at the next edge, force EMPTY regardless of state or simultaneous transfers; payload presented with flush SHALL be dropped; an output transfer coinciding with flush still counts as consumed downstream.
REQ-024 in_ready and out_valid SHALL be driven from registers only when PIPE_SKID_EN defined (no combinational path from out_ready to in_ready).
REQ-025 Sustained in_valid=1, out_ready=1 SHALL give one transfer per cycle.

Reset
REQ-026 While rst_n=0: state EMPTY, out_valid=0, all payload outputs 0, skid contents 0.
REQ-027 in_ready SHALL be 1 during and after reset with PIPE_SKID_EN, and equal out_ready || !out_valid (i.e. 1) without it.
REQ-028 Reset assertion mid-transfer SHALL discard all held entries immediately, without waiting for clk.
REQ-029 First input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro PIPE_SKID_EN defined: two-entry storage per REQ-019..REQ-024, registered in_ready = !(state==TWO).
REQ-031 PIPE_SKID_EN undefined: single entry only, state TWO unreachable, in_ready = out_ready || !out_valid (combinational), all other requirements unchanged.

Verification
REQ-032 Reset: rst_n=0 with in_valid=1, in_opcode=4'hA -> out_valid=0, all outputs 0, in_ready=1; release -> accept at first edge.
REQ-033 Streaming: 8 payloads opcode 1..8, value 8'h10..8'h17, out_ready=1 -> same sequence out, one per cycle, latency 1 edge.
REQ-034 Backpressure (PIPE_SKID_EN): out_ready=0 while sending opcode 3 then 4 -> out shows 3 stable, in_ready=0 after second accept; out_ready=1 -> 3 then 4 out, no loss.
REQ-035 Flush: TWO state holding opcodes 5,6, flush=1 with in_valid=1 opcode 7 -> next cycle out_valid=0, outputs 0, opcode 7 never emerges.
REQ-036 Async reset mid-stream: rst_n pulsed low between edges while out_valid=1, value 8'hFF -> out_valid and out_value 0 immediately.
REQ-037 Without PIPE_SKID_EN: out_ready=0, out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
